// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator: standard video modes
// and the bit ordering of the TMDS control token.
package video_timing_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vt_mode_t;

  localparam vt_mode_t MODE_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33
  };

  localparam vt_mode_t MODE_800X600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
  };

  // Blue-channel control token: c1 carries vsync, c0 carries hsync.
  localparam int CTRL_VSYNC_BIT = 1;
  localparam int CTRL_HSYNC_BIT = 0;

  // Lane positions inside the {blank,vsync,hsync} delay bundle.
  localparam int DLY_BLANK_BIT = 2;
  localparam int DLY_VSYNC_BIT = 1;
  localparam int DLY_HSYNC_BIT = 0;

  function automatic int mode_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_delay_line.sv
// Resettable shift register; every stage loads RESET_VAL on reset so a
// flushed line never emits stale content.
module sync_delay_line #(
  parameter int                 WIDTH     = 3,
  parameter int                 DEPTH     = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters and pixel request at stage 0,
// blank/hsync/vsync delayed to line up with the pixel source's RGB output.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = MODE_640X480_60.h_active,
  parameter int   H_FP       = MODE_640X480_60.h_fp,
  parameter int   H_SYNC     = MODE_640X480_60.h_sync,
  parameter int   H_BP       = MODE_640X480_60.h_bp,
  parameter int   V_ACTIVE   = MODE_640X480_60.v_active,
  parameter int   V_FP       = MODE_640X480_60.v_fp,
  parameter int   V_SYNC     = MODE_640X480_60.v_sync,
  parameter int   V_BP       = MODE_640X480_60.v_bp,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0,
  parameter int   PIPE_DELAY = 2,
  parameter int   CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             pixel_req,
  output logic             line_start,
  output logic             frame_start,
  output logic             blank,
  output logic             hsync,
  output logic             vsync,
  output logic [1:0]       ctrl
);

  localparam int H_TOTAL = mode_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = mode_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Delay bundle resets to blank asserted, both raw syncs inactive.
  localparam logic [2:0] DLY_RESET = 3'b100;

  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_err_zero
    $error("video_timing_gen: active, porch and sync parameters must all be non-zero");
  end

  if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_err_delay
    $error("video_timing_gen: PIPE_DELAY must be in 1..8");
  end

  if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_err_width
    $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + CNT_W'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage 0: everything below decodes the current counter values directly.
  logic h_act, v_act, hs_raw, vs_raw;

  always_comb begin
    h_act  = (h_q < H_ACT);
    v_act  = (v_q < V_ACT);
    hs_raw = (h_q >= HS_BEGIN) && (h_q < HS_END);
    vs_raw = (v_q >= VS_BEGIN) && (v_q < VS_END);
  end

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign pixel_req   = h_act && v_act;
  assign line_start  = !rst && (h_q == '0) && v_act;
  assign frame_start = !rst && (h_q == '0) && (v_q == '0);

  // Stages 1..PIPE_DELAY: raw flags travel together, polarity applied at the end.
  logic [2:0] dly_in, dly_out;

  always_comb begin
    dly_in                = '0;
    dly_in[DLY_BLANK_BIT] = ~pixel_req;
    dly_in[DLY_VSYNC_BIT] = vs_raw;
    dly_in[DLY_HSYNC_BIT] = hs_raw;
  end

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (DLY_RESET)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dly_in),
    .dout (dly_out)
  );

  always_comb begin
    blank                = dly_out[DLY_BLANK_BIT];
    hsync                = dly_out[DLY_HSYNC_BIT] ^ ~HS_POL;
    vsync                = dly_out[DLY_VSYNC_BIT] ^ ~VS_POL;
    ctrl                 = '0;
    ctrl[CTRL_VSYNC_BIT] = vsync;
    ctrl[CTRL_HSYNC_BIT] = hsync;
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: several parameterisations checked every cycle
// against an elapsed-cycle model, plus literal expectations at key points.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  // Index 0: defaults PD2, 1: PD1, 2: PD8, 3: short-vertical PD3, 4: defaults PD2 (mid-frame reset)
  logic [11:0] px [5];
  logic [11:0] py [5];
  logic        req [5];
  logic        ls  [5];
  logic        fs  [5];
  logic        bl  [5];
  logic        hs  [5];
  logic        vs  [5];
  logic [1:0]  ctl [5];

  logic [3:0]  t_px, t_py;
  logic        t_req, t_ls, t_fs, t_bl, t_hs, t_vs;
  logic [1:0]  t_ctl;

  video_timing_gen #(.PIPE_DELAY(2)) u_d2 (
    .clk(clk), .rst(rst_a), .pixel_x(px[0]), .pixel_y(py[0]), .pixel_req(req[0]),
    .line_start(ls[0]), .frame_start(fs[0]), .blank(bl[0]), .hsync(hs[0]),
    .vsync(vs[0]), .ctrl(ctl[0]));

  video_timing_gen #(.PIPE_DELAY(1)) u_d1 (
    .clk(clk), .rst(rst_a), .pixel_x(px[1]), .pixel_y(py[1]), .pixel_req(req[1]),
    .line_start(ls[1]), .frame_start(fs[1]), .blank(bl[1]), .hsync(hs[1]),
    .vsync(vs[1]), .ctrl(ctl[1]));

  video_timing_gen #(.PIPE_DELAY(8)) u_d8 (
    .clk(clk), .rst(rst_a), .pixel_x(px[2]), .pixel_y(py[2]), .pixel_req(req[2]),
    .line_start(ls[2]), .frame_start(fs[2]), .blank(bl[2]), .hsync(hs[2]),
    .vsync(vs[2]), .ctrl(ctl[2]));

  video_timing_gen #(.V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(3)) u_sv (
    .clk(clk), .rst(rst_a), .pixel_x(px[3]), .pixel_y(py[3]), .pixel_req(req[3]),
    .line_start(ls[3]), .frame_start(fs[3]), .blank(bl[3]), .hsync(hs[3]),
    .vsync(vs[3]), .ctrl(ctl[3]));

  video_timing_gen #(.PIPE_DELAY(2)) u_m2 (
    .clk(clk), .rst(rst_b), .pixel_x(px[4]), .pixel_y(py[4]), .pixel_req(req[4]),
    .line_start(ls[4]), .frame_start(fs[4]), .blank(bl[4]), .hsync(hs[4]),
    .vsync(vs[4]), .ctrl(ctl[4]));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(2), .CNT_W(4)) u_tn (
    .clk(clk), .rst(rst_c), .pixel_x(t_px), .pixel_y(t_py), .pixel_req(t_req),
    .line_start(t_ls), .frame_start(t_fs), .blank(t_bl), .hsync(t_hs),
    .vsync(t_vs), .ctrl(t_ctl));

  localparam int VA_T[5] = '{480, 480, 480, 6, 480};
  localparam int VF_T[5] = '{10, 10, 10, 1, 10};
  localparam int VS_T[5] = '{2, 2, 2, 2, 2};
  localparam int VB_T[5] = '{33, 33, 33, 3, 33};
  localparam int PD_T[5] = '{2, 1, 8, 3, 2};
  localparam string NM_T[5] = '{"d2", "d1", "d8", "sv", "m2"};

  int  n_chk  = 0;
  int  n_pass = 0;
  int  cyc    = 0;
  int  k_a = 0, k_b = 0, k_c = 0;
  bit  live_a = 1'b0, live_b = 1'b0, live_c = 1'b0;

  // k counts clock edges since the last edge that sampled reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_a) begin k_a <= 0; live_a <= 1'b1; end else k_a <= k_a + 1;
    if (rst_b) begin k_b <= 0; live_b <= 1'b1; end else k_b <= k_b + 1;
    if (rst_c) begin k_c <= 0; live_c <= 1'b1; end else k_c <= k_c + 1;
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    else
      n_pass++;
  endtask

  // Expected outputs from elapsed cycles: position is k mod frame, delayed
  // outputs are the same rules evaluated at k-PD, reset values before that.
  task automatic check_inst(input string nm, input int k, input logic r,
                            input int ha, input int hf, input int hsw, input int hb,
                            input int va, input int vf, input int vsw, input int vb,
                            input int pd, input logic hp, input logic vp,
                            input logic [31:0] ax, input logic [31:0] ay,
                            input logic areq, input logic als, input logic afs,
                            input logic abl, input logic ahs, input logic avs,
                            input logic [1:0] actl);
    int ht, vt, h, v, h2, v2;
    logic e_bl, e_hs, e_vs;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    h  = k % ht;
    v  = (k / ht) % vt;
    if (k < pd) begin
      e_bl = 1'b1;
      e_hs = ~hp;
      e_vs = ~vp;
    end else begin
      h2   = (k - pd) % ht;
      v2   = ((k - pd) / ht) % vt;
      e_bl = !((h2 < ha) && (v2 < va));
      e_hs = ((h2 >= ha + hf) && (h2 < ha + hf + hsw)) ? hp : ~hp;
      e_vs = ((v2 >= va + vf) && (v2 < va + vf + vsw)) ? vp : ~vp;
    end
    chk32({nm, ".pixel_x"}, ax, 32'(h));
    chk32({nm, ".pixel_y"}, ay, 32'(v));
    chk1({nm, ".pixel_req"}, areq, (h < ha) && (v < va));
    chk1({nm, ".line_start"}, als, !r && (h == 0) && (v < va));
    chk1({nm, ".frame_start"}, afs, !r && (h == 0) && (v == 0));
    chk1({nm, ".blank"}, abl, e_bl);
    chk1({nm, ".hsync"}, ahs, e_hs);
    chk1({nm, ".vsync"}, avs, e_vs);
    chk32({nm, ".ctrl"}, 32'(actl), 32'({e_vs, e_hs}));
  endtask

  always @(negedge clk) begin
    if (live_a)
      for (int i = 0; i < 4; i++)
        check_inst(NM_T[i], k_a, rst_a, 640, 16, 96, 48, VA_T[i], VF_T[i], VS_T[i], VB_T[i],
                   PD_T[i], 1'b0, 1'b0, 32'(px[i]), 32'(py[i]), req[i], ls[i], fs[i],
                   bl[i], hs[i], vs[i], ctl[i]);
    if (live_b)
      check_inst(NM_T[4], k_b, rst_b, 640, 16, 96, 48, VA_T[4], VF_T[4], VS_T[4], VB_T[4],
                 PD_T[4], 1'b0, 1'b0, 32'(px[4]), 32'(py[4]), req[4], ls[4], fs[4],
                 bl[4], hs[4], vs[4], ctl[4]);
    if (live_c)
      check_inst("tn", k_c, rst_c, 4, 1, 2, 1, 3, 1, 1, 1, 2, 1'b1, 1'b1,
                 32'(t_px), 32'(t_py), t_req, t_ls, t_fs, t_bl, t_hs, t_vs, t_ctl);

    // Hand-computed literals that pin the model itself.
    if (live_a && !rst_a) begin
      case (k_a)
        0:    begin chk1("pin d2 req@0", req[0], 1'b1); chk1("pin d2 fs@0", fs[0], 1'b1);
                    chk1("pin d2 ls@0", ls[0], 1'b1);   chk1("pin d2 blank@0", bl[0], 1'b1);
                    chk1("pin d1 blank@0", bl[1], 1'b1); end
        1:    begin chk1("pin d2 blank@1", bl[0], 1'b1); chk1("pin d1 blank@1", bl[1], 1'b0); end
        2:    chk1("pin d2 blank@2", bl[0], 1'b0);
        7:    chk1("pin d8 blank@7", bl[2], 1'b1);
        8:    chk1("pin d8 blank@8", bl[2], 1'b0);
        639:  chk1("pin d2 req@639", req[0], 1'b1);
        640:  chk1("pin d2 req@640", req[0], 1'b0);
        641:  chk1("pin d2 blank@641", bl[0], 1'b0);
        642:  chk1("pin d2 blank@642", bl[0], 1'b1);
        657:  chk1("pin d2 hsync@657", hs[0], 1'b1);
        658:  chk1("pin d2 hsync@658", hs[0], 1'b0);
        700:  chk32("pin d2 ctrl@700", 32'(ctl[0]), 32'd2);
        753:  chk1("pin d2 hsync@753", hs[0], 1'b0);
        754:  chk1("pin d2 hsync@754", hs[0], 1'b1);
        800:  begin chk32("pin d2 x@800", 32'(px[0]), 32'd0); chk32("pin d2 y@800", 32'(py[0]), 32'd1);
                    chk1("pin d2 ls@800", ls[0], 1'b1); chk1("pin d2 fs@800", fs[0], 1'b0); end
        5602: chk1("pin sv vsync@5602", vs[3], 1'b1);
        5603: chk1("pin sv vsync@5603", vs[3], 1'b0);
        7202: chk1("pin sv vsync@7202", vs[3], 1'b0);
        7203: chk1("pin sv vsync@7203", vs[3], 1'b1);
        9599: begin chk32("pin sv x@9599", 32'(px[3]), 32'd799); chk32("pin sv y@9599", 32'(py[3]), 32'd11); end
        9600: begin chk32("pin sv x@9600", 32'(px[3]), 32'd0); chk32("pin sv y@9600", 32'(py[3]), 32'd0);
                    chk1("pin sv fs@9600", fs[3], 1'b1); end
        default: ;
      endcase
    end
    if (live_b && !rst_b) begin
      case (k_b)
        0: begin chk32("pin m2 x@0", 32'(px[4]), 32'd0); chk32("pin m2 y@0", 32'(py[4]), 32'd0);
                 chk1("pin m2 fs@0", fs[4], 1'b1); chk1("pin m2 blank@0", bl[4], 1'b1); end
        1: chk1("pin m2 blank@1", bl[4], 1'b1);
        2: chk1("pin m2 blank@2", bl[4], 1'b0);
        default: ;
      endcase
    end
    if (live_c && !rst_c) begin
      case (k_c)
        0:  begin chk1("pin tn hsync@0", t_hs, 1'b0); chk1("pin tn vsync@0", t_vs, 1'b0);
                  chk1("pin tn blank@0", t_bl, 1'b1); end
        1:  begin chk1("pin tn hsync@1", t_hs, 1'b0); chk1("pin tn vsync@1", t_vs, 1'b0); end
        6:  chk1("pin tn hsync@6", t_hs, 1'b0);
        7:  chk1("pin tn hsync@7", t_hs, 1'b1);
        8:  chk1("pin tn hsync@8", t_hs, 1'b1);
        9:  chk1("pin tn hsync@9", t_hs, 1'b0);
        33: chk1("pin tn vsync@33", t_vs, 1'b0);
        34: chk1("pin tn vsync@34", t_vs, 1'b1);
        41: chk1("pin tn vsync@41", t_vs, 1'b1);
        42: chk1("pin tn vsync@42", t_vs, 1'b0);
        48: chk1("pin tn fs@48", t_fs, 1'b1);
        default: ;
      endcase
    end
  end

  task automatic reset_at(input int which, input int target, input int budget);
    int k;
    for (int i = 0; i < budget; i++) begin
      k = (which == 0) ? k_c : k_b;
      if (k == target) break;
      @(posedge clk); #2;
    end
    k = (which == 0) ? k_c : k_b;
    n_chk++;
    if (k != target) begin
      $display("FAIL reset_wait[%0d]: reached %0d expected %0d", which, k, target);
    end else begin
      n_pass++;
    end
    if (which == 0) rst_c = 1'b1; else rst_b = 1'b1;
    @(posedge clk); #2;
    if (which == 0) rst_c = 1'b0; else rst_b = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    // Tiny mode: reset with hsync and vsync both in flight (h=6, v=4, second frame).
    reset_at(0, 48 + 38, 200);
    repeat (60) @(posedge clk);
    #2;
    // Defaults: reset in the middle of an active line (x=300, y=20).
    reset_at(1, 20 * 800 + 300, 20000);
    repeat (4000) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
